// File: rtl/sram_banked_ctrl.sv
// Banked, byte-maskable single-port SRAM with valid/ready requests, fixed-latency
// read response (1 or 2 cycles) and a clear engine that zeroes one row per bank per cycle.
module sram_banked_ctrl #(
    parameter int BW_DATA  = 64,
    parameter int BW_ADDR  = 6,
    parameter int NUM_BANK = 4,
    parameter int RD_LAT   = 1,
    parameter int BW_BE    = BW_DATA / 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic               i_req_wen,
    input  logic [BW_ADDR-1:0] i_req_addr,
    input  logic [BW_DATA-1:0] i_req_data,
    input  logic [BW_BE-1:0]   i_req_be,
    output logic               o_rsp_valid,
    output logic [BW_DATA-1:0] o_rsp_data,
    input  logic               i_clr,
    output logic               o_busy
);

    localparam int DEPTH   = 1 << BW_ADDR;
    localparam int ROWS    = DEPTH / NUM_BANK;
    localparam int BW_BANK = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
    localparam int BW_ROW  = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state;
    logic [BW_ROW-1:0]   clr_row;
    logic [BW_DATA-1:0]  mem [NUM_BANK][ROWS];

    logic [BW_BANK-1:0]  req_bank;
    logic [BW_ROW-1:0]   req_row;
    logic [BW_DATA-1:0]  rd_word;
    logic                accept;
    logic                wr_fire;
    logic                rd_fire;
    logic                pipe_valid;
    logic [BW_DATA-1:0]  pipe_data;

    // Low address bits select the bank, so consecutive words interleave across banks.
    assign req_bank = BW_BANK'(i_req_addr % NUM_BANK);
    assign req_row  = BW_ROW'(i_req_addr / NUM_BANK);
    assign rd_word  = mem[req_bank][req_row];

    assign o_req_ready = (state == IDLE) && !i_clr;
    assign accept      = i_req_valid && o_req_ready && !i_rst;
    assign wr_fire     = accept && i_req_wen;
    assign rd_fire     = accept && !i_req_wen;

    // NOTE: the array has no reset branch; storage keeps its contents through i_rst.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (state == CLEAR) begin
                for (int b = 0; b < NUM_BANK; b++) begin
                    mem[b][clr_row] <= '0;
                end
            end else if (wr_fire) begin
                for (int k = 0; k < BW_BE; k++) begin
                    if (i_req_be[k]) begin
                        mem[req_bank][req_row][8*k +: 8] <= i_req_data[8*k +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            clr_row <= '0;
            o_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_clr) begin
                        state   <= CLEAR;
                        clr_row <= '0;
                        o_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_row == BW_ROW'(ROWS - 1)) begin
                        state   <= IDLE;
                        clr_row <= '0;
                        o_busy  <= 1'b0;
                    end else begin
                        clr_row <= clr_row + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic               s1_valid;
            logic [BW_DATA-1:0] s1_data;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                end else begin
                    s1_valid <= rd_fire;
                    if (rd_fire) begin
                        s1_data <= rd_word;
                    end
                end
            end

            assign pipe_valid = s1_valid;
            assign pipe_data  = s1_data;
        end else begin : g_lat1
            assign pipe_valid = rd_fire;
            assign pipe_data  = rd_word;
        end
    endgenerate

    // Response data only moves on a valid beat, so it holds between responses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
        end else begin
            o_rsp_valid <= pipe_valid;
            if (pipe_valid) begin
                o_rsp_data <= pipe_data;
            end
        end
    end

endmodule

// File: tb/tb_sram_banked_ctrl.sv
// Self-checking bench: RD_LAT=1 and RD_LAT=2 instances share stimulus and are
// compared every cycle against a word-array/response-queue model of the memory.
module tb_sram_banked_ctrl;

    localparam int NB   = 4;
    localparam int ROWS = 16;

    typedef struct {
        int          due;
        logic [63:0] data;
    } rsp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_wen;
    logic [5:0]  req_addr;
    logic [63:0] req_data;
    logic [7:0]  req_be;
    logic        clr;

    logic        ready1, valid1, busy1;
    logic        ready2, valid2, busy2;
    logic [63:0] data1, data2;

    int checks   = 0;
    int failures = 0;

    sram_banked_ctrl #(.RD_LAT(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready1),
        .i_req_wen(req_wen), .i_req_addr(req_addr), .i_req_data(req_data),
        .i_req_be(req_be), .o_rsp_valid(valid1), .o_rsp_data(data1),
        .i_clr(clr), .o_busy(busy1)
    );

    sram_banked_ctrl #(.RD_LAT(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready2),
        .i_req_wen(req_wen), .i_req_addr(req_addr), .i_req_data(req_data),
        .i_req_be(req_be), .o_rsp_valid(valid2), .o_rsp_data(data2),
        .i_clr(clr), .o_busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: plain word array, remaining clear cycles, expected responses.
    logic [63:0] mm [64];
    int          cyc = 0;
    int          clr_left = 0;
    rsp_t        q1[$];
    rsp_t        q2[$];
    logic [63:0] exp_d1 = '0;
    logic [63:0] exp_d2 = '0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            clr_left = 0;
            q1.delete();
            q2.delete();
            exp_d1 = '0;
            exp_d2 = '0;
        end else if (clr_left > 0) begin
            for (int b = 0; b < NB; b++) mm[(ROWS - clr_left) * NB + b] = '0;
            clr_left--;
        end else if (clr) begin
            clr_left = ROWS;
        end else if (req_valid) begin
            if (req_wen) begin
                for (int k = 0; k < 8; k++)
                    if (req_be[k]) mm[req_addr][8*k +: 8] = req_data[8*k +: 8];
            end else begin
                q1.push_back('{cyc, mm[req_addr]});
                q2.push_back('{cyc + 1, mm[req_addr]});
            end
        end
    end

    // Observed-response bookkeeping used by the literal checks.
    logic [63:0] last_rsp1 = '0;
    logic [63:0] last_rsp2 = '0;
    int          busy_cnt1 = 0;
    int          busy_cnt2 = 0;
    int          rsp_cnt1  = 0;
    int          rsp_cnt2  = 0;

    always @(negedge clk) begin
        if (cyc > 0) begin
            logic ev1, ev2;
            ev1 = (q1.size() > 0) && (q1[0].due == cyc);
            ev2 = (q2.size() > 0) && (q2[0].due == cyc);
            if (ev1) begin exp_d1 = q1[0].data; void'(q1.pop_front()); end
            if (ev2) begin exp_d2 = q2[0].data; void'(q2.pop_front()); end
            check("rsp_valid_l1", valid1, ev1);
            check("rsp_valid_l2", valid2, ev2);
            check("rsp_data_l1", data1, exp_d1);
            check("rsp_data_l2", data2, exp_d2);
            check("busy_l1", busy1, clr_left > 0);
            check("busy_l2", busy2, clr_left > 0);
            check("ready_l1", ready1, (clr_left == 0) && !clr);
            check("ready_l2", ready2, (clr_left == 0) && !clr);
            if (valid1) begin last_rsp1 = data1; rsp_cnt1++; end
            if (valid2) begin last_rsp2 = data2; rsp_cnt2++; end
            if (busy1) busy_cnt1++;
            if (busy2) busy_cnt2++;
        end
    end

    task automatic drive(input logic v, input logic w, input logic [5:0] a,
                         input logic [63:0] d, input logic [7:0] be,
                         input logic c, input logic r);
        @(negedge clk);
        #1;
        req_valid = v; req_wen = w; req_addr = a; req_data = d; req_be = be;
        clr = c; rst = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 6'd0, 64'd0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [5:0] a, input logic [63:0] d, input logic [7:0] be);
        drive(1'b1, 1'b1, a, d, be, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [5:0] a);
        drive(1'b1, 1'b0, a, 64'd0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic read_lit(input logic [5:0] a, input logic [63:0] exp, input string name);
        rd(a);
        idle(2);
        check({name, "_l1"}, last_rsp1, exp);
        check({name, "_l2"}, last_rsp2, exp);
    endtask

    logic [63:0] wdat [64];

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
        req_data = '0; req_be = '0; clr = 1'b0;
        drive(1'b0, 1'b0, 6'd0, 64'd0, 8'h00, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 6'd0, 64'd0, 8'h00, 1'b0, 1'b1);
        check("reset_valid", valid1, 1'b0);
        check("reset_data", data2, 64'd0);
        check("reset_busy", busy1, 1'b0);
        idle(1);
        check("ready_after_reset", ready1, 1'b1);

        // Plain write then read on the next cycle.
        wr(6'd5, 64'h0123_4567_89AB_CDEF, 8'hFF);
        read_lit(6'd5, 64'h0123_4567_89AB_CDEF, "t1_raw");

        // Byte mask: only the low four bytes get zeroed.
        wr(6'd9, {64{1'b1}}, 8'hFF);
        wr(6'd9, 64'h0, 8'h0F);
        read_lit(6'd9, 64'hFFFF_FFFF_0000_0000, "t2_mask");
        wr(6'd9, 64'h0, 8'h00);
        read_lit(6'd9, 64'hFFFF_FFFF_0000_0000, "t2_be_zero");

        // Fill every word, then stream all of it back.
        for (int a = 0; a < 64; a++) begin
            wdat[a] = {$urandom, $urandom};
            wr(6'(a), wdat[a], 8'hFF);
        end
        rsp_cnt1 = 0;
        rsp_cnt2 = 0;
        for (int a = 0; a < 64; a++) rd(6'(a));
        idle(3);
        check("t3_count_l1", 64'(rsp_cnt1), 64'd64);
        check("t3_count_l2", 64'(rsp_cnt2), 64'd64);
        check("t3_last_l1", last_rsp1, wdat[63]);
        check("t3_last_l2", last_rsp2, wdat[63]);

        // Clear a full array.
        busy_cnt1 = 0;
        busy_cnt2 = 0;
        drive(1'b0, 1'b0, 6'd0, 64'd0, 8'h00, 1'b1, 1'b0);
        idle(20);
        check("t4_busy_len_l1", 64'(busy_cnt1), 64'd16);
        check("t4_busy_len_l2", 64'(busy_cnt2), 64'd16);
        for (int a = 0; a < 64; a++) rd(6'(a));
        idle(3);
        read_lit(6'd63, 64'd0, "t4_cleared");

        // Clear beats a simultaneous write; a second i_clr mid-clear is ignored.
        wr(6'd3, 64'hA5A5_5A5A_A5A5_5A5A, 8'hFF);
        busy_cnt1 = 0;
        drive(1'b1, 1'b1, 6'd3, {64{1'b1}}, 8'hFF, 1'b1, 1'b0);
        idle(4);
        drive(1'b0, 1'b0, 6'd0, 64'd0, 8'h00, 1'b1, 1'b0);
        idle(15);
        check("t5_busy_len", 64'(busy_cnt1), 64'd16);
        read_lit(6'd3, 64'd0, "t5_collision");

        // Reset eight cycles into a clear.
        wr(6'd62, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
        wr(6'd1, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF);
        rd(6'd62);
        busy_cnt1 = 0;
        drive(1'b0, 1'b0, 6'd0, 64'd0, 8'h00, 1'b1, 1'b0);
        idle(7);
        drive(1'b0, 1'b0, 6'd0, 64'd0, 8'h00, 1'b0, 1'b1);
        idle(1);
        check("t6_busy_after_rst", busy1, 1'b0);
        check("t6_valid_after_rst", valid2, 1'b0);
        check("t6_busy_len", 64'(busy_cnt1), 64'd8);
        read_lit(6'd62, 64'hDEAD_BEEF_CAFE_F00D, "t6_uncleared_row");
        wr(6'd1, 64'h1111_2222_3333_4444, 8'hFF);
        read_lit(6'd1, 64'h1111_2222_3333_4444, "t6_after_rst");
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_banked_ctrl.md
Name: sram_banked_ctrl

Overview:
Parametrised successor to the single-port SRAM model. It is a banked, byte-maskable SRAM with a valid/ready request port and a fixed-latency read response (1 or 2 cycles). A built-in clear engine zeroes the whole array on command. It sits between the training datapath blocks and on-chip storage, and it is the standard memory macro wrapper for subsequent projects.

Parameters:
BW_DATA, 64, data width in bits; must be a multiple of 8.
BW_ADDR, 6, word-address width; total depth DEPTH = 2^BW_ADDR words.
NUM_BANK, 4, number of banks; power of 2, at least 1, at most DEPTH.
RD_LAT, 1, read latency in cycles; legal values are 1 or 2.
BW_BE, BW_DATA/8, byte-enable width (derived; do not override).

Ports:
i_clk  in  1  clock; all logic on rising edge.
i_rst  in  1  synchronous reset, active-high.
i_req_valid  in  1  request valid.
o_req_ready  out  1  request ready.
i_req_wen  in  1  1 = write, 0 = read.
i_req_addr  in  BW_ADDR  word address.
i_req_data  in  BW_DATA  write data.
i_req_be  in  BW_BE  byte enables; bit k covers data[8k+7:8k].
o_rsp_valid  out  1  read data valid (single-cycle pulse per read).
o_rsp_data  out  BW_DATA  read data.
i_clr  in  1  start clear of whole array.
o_busy  out  1  clear in progress.

Behaviour:
- Clocking/reset: one clock i_clk. Reset is synchronous and active-high on i_rst.
- Reset state: FSM goes to IDLE, clear counter = 0, read pipeline flushed, o_rsp_valid = 0, o_rsp_data = 0, o_busy = 0. Memory contents are NOT reset.
- Address map: bank = i_req_addr[log2(NUM_BANK)-1:0], row = remaining upper bits. With NUM_BANK = 1 all bits are row.
- FSM states: IDLE and CLEAR.
  - IDLE to CLEAR when i_clr = 1 at a rising edge.
  - CLEAR to IDLE after the last row is written.
- Ready: o_req_ready = (state == IDLE) && !i_clr. This is combinational. Clear wins over a simultaneous request: the request is not accepted and must be held by the requester.
- Accept: a request is accepted at a rising edge when i_req_valid && o_req_ready.
- Write: at the accept edge, only bytes with be = 1 are updated; other bytes keep their value. be = 0 gives a write with no effect. A write produces no response.
- Read accepted at edge N:
  - o_rsp_valid = 1 for exactly one cycle, starting after edge N+RD_LAT-1. RD_LAT = 1 means valid immediately after edge N.
  - There is no response backpressure.
  - Back-to-back reads return one response per cycle, in order.
- Read-after-write: a read accepted one cycle after a write to the same address returns the new data.
- o_rsp_data holds its last value while o_rsp_valid = 0.
- CLEAR:
  - All NUM_BANK banks zero row r in parallel at each edge, with r counting 0 .. DEPTH/NUM_BANK-1.
  - Duration is exactly DEPTH/NUM_BANK cycles. o_busy = 1 for exactly that span, starting the cycle after the i_clr edge.
  - o_req_ready = 0 throughout CLEAR. i_clr asserted during CLEAR is ignored (no restart, no extension).
- Reads accepted before the clear still deliver their response (with RD_LAT = 2, one may complete during CLEAR). The data returned is the pre-clear value.
- i_rst mid-CLEAR: abort, return to IDLE next cycle, o_busy = 0. Rows not yet cleared keep their old contents.
- Width rules: byte-enable masking is per byte. Address arithmetic is unsigned. The clear counter wraps only to exit.

Test Plan:
1. RD_LAT=1: write addr 5 = 64'h0123_4567_89AB_CDEF with be = 8'hFF, read addr 5 next cycle -> o_rsp_valid high one cycle after the read accept with that data; o_rsp_valid low otherwise.
2. Byte mask: write addr 9 = all ones (be = FF), then addr 9 = 64'h0 with be = 8'h0F, read -> 64'hFFFF_FFFF_0000_0000.
3. Back-to-back: write addresses 0..63 with random data, then 64 consecutive reads -> 64 consecutive valid pulses, in order, all matching; repeat with RD_LAT = 2 -> the same sequence shifted by one cycle.
4. Clear: fill memory, pulse i_clr -> o_busy high exactly 16 cycles (defaults 64/4), o_req_ready low throughout; all 64 reads afterwards return 0.
5. Collision: i_clr and a write to addr 3 in the same cycle -> write not accepted, clear runs; addr 3 reads 0 afterwards. An i_clr pulse mid-clear -> o_busy length is unchanged.
6. Reset mid-clear: assert i_rst at cycle 8 of the clear -> o_busy = 0 and o_rsp_valid = 0 next cycle; a subsequent write/read of addr 1 works normally.
